// File: rtl/visor_resultado_7seg.sv
`timescale 1ns/1ps
// visor_resultado_7seg
//
// Display end of the ALU result bus. A capture request (init) latches the 6-bit
// unsigned result, a sequential double-dabble engine turns it into tens/units
// BCD digits over six clocks, and the committed digits are shown on a
// multiplexed 4-digit common-anode 7-segment display.
//
// Parameters
//   REFRESH_DIV : clk cycles each digit slot stays selected (>= 2)
//
// Ports
//   clk   : system clock, all state changes on its rising edge
//   rst   : asynchronous active-high reset
//   init  : capture request, sampled on every clk edge
//   dato  : 6-bit unsigned value to display (0..63)
//   sseg  : segments {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit anodes, active-low, registered; an[0]=units, an[1]=tens
//   busy  : high while a conversion is in progress
//   listo : one-cycle pulse when new digits reach the display registers
module visor_resultado_7seg #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic [5:0] dato,
    output logic [6:0] sseg,
    output logic [3:0] an,
    output logic       busy,
    output logic       listo
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] REF_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHOW
    } state_t;

    state_t           state_q, state_d;
    // Double-dabble working register: {tens, units, binary}
    logic [13:0]      shift_q, shift_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic             disp_ok_q, disp_ok_d;
    logic             listo_q, listo_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       sel_q, sel_d;
    logic [6:0]       sseg_q, sseg_d;
    logic [3:0]       an_q, an_d;

    logic [13:0]      adj;
    logic [13:0]      step;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // One double-dabble iteration: correct any BCD nibble >= 5 so the
    // following shift carries properly into the next decade, then shift.
    // Tens never exceeds 3 before the final shift, but it is corrected anyway
    // to keep the step uniform.
    always_comb begin
        adj = shift_q;
        if (adj[9:6] >= 4'd5) begin
            adj[9:6] = adj[9:6] + 4'd3;
        end
        if (adj[13:10] >= 4'd5) begin
            adj[13:10] = adj[13:10] + 4'd3;
        end
        step = adj << 1;
    end

    // State register and all sequential state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            units_q   <= '0;
            tens_q    <= '0;
            disp_ok_q <= 1'b0;
            listo_q   <= 1'b0;
            refresh_q <= '0;
            sel_q     <= '0;
            sseg_q    <= 7'h7F;
            an_q      <= 4'hF;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            units_q   <= units_d;
            tens_q    <= tens_d;
            disp_ok_q <= disp_ok_d;
            listo_q   <= listo_d;
            refresh_q <= refresh_d;
            sel_q     <= sel_d;
            sseg_q    <= sseg_d;
            an_q      <= an_d;
        end
    end

    // Next-state logic. The display registers are only written when a
    // conversion finishes, so the old value stays visible during CONV.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        units_d   = units_q;
        tens_d    = tens_q;
        disp_ok_d = disp_ok_q;
        listo_d   = 1'b0;
        case (state_q)
            IDLE, SHOW: begin
                if (init) begin
                    shift_d = {8'b0, dato};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                shift_d = step;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd5) begin
                    units_d   = step[9:6];
                    tens_d    = step[13:10];
                    disp_ok_d = 1'b1;
                    listo_d   = 1'b1;
                    state_d   = SHOW;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        busy  = (state_q == CONV);
        listo = listo_q;
    end

    // Free-running digit refresh, independent of the FSM
    always_comb begin
        refresh_d = refresh_q + 1'b1;
        sel_d     = sel_q;
        if (refresh_q == REF_MAX) begin
            refresh_d = '0;
            sel_d     = sel_q + 2'd1;
        end
    end

    // Digit multiplexer; its result is registered so the pins never glitch.
    // Slots 2 and 3 are unused and a zero tens digit is blanked.
    always_comb begin
        sseg_d = 7'h7F;
        an_d   = 4'hF;
        if (disp_ok_q) begin
            case (sel_q)
                2'd0: begin
                    an_d   = 4'b1110;
                    sseg_d = seg_decode(units_q);
                end
                2'd1: begin
                    if (tens_q != 4'd0) begin
                        an_d   = 4'b1101;
                        sseg_d = seg_decode(tens_q);
                    end
                end
                default: begin
                    an_d   = 4'hF;
                    sseg_d = 7'h7F;
                end
            endcase
        end
    end

    assign sseg = sseg_q;
    assign an   = an_q;

endmodule
